// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the core's single memory port: instruction fetch vs load/store.
// Round-robin on ties, latched request held to memory, registered ready pulses, watchdog abort.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              nRST,
  input  logic              iren,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              iready,
  output logic [DATA_W-1:0] instr,
  input  logic              dren,
  input  logic              dwen,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic              dready,
  output logic [DATA_W-1:0] dload,
  output logic              mem_ren,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              err
);

  // state | meaning
  // IDLE  | no access in flight, arbitrate masked requests
  // IBUSY | fetch granted, mem_ren with latched fetch address
  // DBUSY | load/store granted, mem_ren or mem_wen with latched address/data
  typedef enum logic [1:0] {IDLE, IBUSY, DBUSY} state_t;

  // Watchdog is a down-counter loaded with TIMEOUT-1 on grant; terminal count at zero.
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  state_t            state, state_nxt;
  logic              last_data;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              wr_q;
  logic [CNT_W-1:0]  cnt;

  logic i_req, d_req;
  logic grant_i, grant_d;
  logic done, abort;
  logic busy, timeout_hit;

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    grant_i     = 1'b0;
    grant_d     = 1'b0;
    done        = 1'b0;
    abort       = 1'b0;
    mem_ren     = 1'b0;
    mem_wen     = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    i_req       = iren & ~iready;
    d_req       = (dren | dwen) & ~dready;
    busy        = (state != IDLE);
    timeout_hit = (TIMEOUT > 0) && (cnt == '0);
    case (state)
      IDLE: begin
        if (i_req && d_req) begin
          grant_i = last_data;
          grant_d = ~last_data;
        end else begin
          grant_i = i_req;
          grant_d = d_req & ~i_req;
        end
        if (grant_i)      state_nxt = IBUSY;
        else if (grant_d) state_nxt = DBUSY;
      end
      IBUSY: begin
        mem_ren  = 1'b1;
        mem_addr = addr_q;
        if (mem_ack) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end else if (timeout_hit) begin
          abort     = 1'b1;
          state_nxt = IDLE;
        end
      end
      DBUSY: begin
        mem_wen   = wr_q;
        mem_ren   = ~wr_q;
        mem_addr  = addr_q;
        mem_wdata = wr_q ? wdata_q : '0;
        if (mem_ack) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end else if (timeout_hit) begin
          abort     = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      last_data <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wr_q      <= 1'b0;
      cnt       <= '0;
      iready    <= 1'b0;
      dready    <= 1'b0;
      err       <= 1'b0;
      instr     <= '0;
      dload     <= '0;
    end else begin
      if (grant_i) begin
        addr_q    <= iaddr;
        last_data <= 1'b0;
        cnt       <= CNT_LOAD;
      end else if (grant_d) begin
        addr_q    <= daddr;
        wdata_q   <= dstore;
        wr_q      <= dwen;
        last_data <= 1'b1;
        cnt       <= CNT_LOAD;
      end else if (busy && !mem_ack && (cnt != '0)) begin
        cnt <= cnt - CNT_W'(1);
      end
      iready <= (done || abort) && (state == IBUSY);
      dready <= (done || abort) && (state == DBUSY);
      err    <= abort;
      if (done && (state == IBUSY))
        instr <= mem_rdata;
      if (done && (state == DBUSY) && !wr_q)
        dload <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios with literal expectations,
// then random traffic compared every cycle against a transaction-level model.
module tb_mem_port_arbiter;
  localparam int TIMEOUT = 4;

  logic        clk;
  logic        nRST;
  logic        iren, dren, dwen, mem_ack;
  logic [31:0] iaddr, daddr, dstore, mem_rdata;
  logic        iready, dready, mem_ren, mem_wen, err;
  logic [31:0] instr, dload, mem_addr, mem_wdata;

  int n_checks = 0;
  int n_fail   = 0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .nRST(nRST),
    .iren(iren), .iaddr(iaddr), .iready(iready), .instr(instr),
    .dren(dren), .dwen(dwen), .daddr(daddr), .dstore(dstore),
    .dready(dready), .dload(dload),
    .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Transaction-level model: who owns the port, how long it has waited, what was captured.
  int          m_owner;      // 0 none, 1 fetch, 2 data
  int          m_waited;
  int          pick;
  logic        m_last_data, m_write;
  logic [31:0] m_addr, m_wdata, m_instr, m_dload;
  logic        m_iready, m_dready, m_err;
  logic        ir, dr;

  always @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      m_owner = 0; m_waited = 0; m_last_data = 1'b0; m_write = 1'b0;
      m_addr = '0; m_wdata = '0; m_instr = '0; m_dload = '0;
      m_iready = 1'b0; m_dready = 1'b0; m_err = 1'b0;
    end else begin
      ir = iren && !m_iready;
      dr = (dren || dwen) && !m_dready;
      m_iready = 1'b0; m_dready = 1'b0; m_err = 1'b0;
      if (m_owner == 0) begin
        if (ir && dr)  pick = m_last_data ? 1 : 2;
        else if (ir)   pick = 1;
        else if (dr)   pick = 2;
        else           pick = 0;
        if (pick == 1) begin
          m_owner = 1; m_addr = iaddr; m_last_data = 1'b0; m_waited = 0;
        end else if (pick == 2) begin
          m_owner = 2; m_addr = daddr; m_wdata = dstore; m_write = dwen;
          m_last_data = 1'b1; m_waited = 0;
        end
      end else if (mem_ack) begin
        if (m_owner == 1) begin
          m_instr = mem_rdata; m_iready = 1'b1;
        end else begin
          if (!m_write) m_dload = mem_rdata;
          m_dready = 1'b1;
        end
        m_owner = 0;
      end else begin
        m_waited++;
        if (TIMEOUT > 0 && m_waited == TIMEOUT) begin
          m_err = 1'b1;
          if (m_owner == 1) m_iready = 1'b1;
          else              m_dready = 1'b1;
          m_owner = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk1 ("mem_ren",   mem_ren,   (m_owner == 1) || (m_owner == 2 && !m_write));
    chk1 ("mem_wen",   mem_wen,   (m_owner == 2) && m_write);
    chk32("mem_addr",  mem_addr,  (m_owner != 0) ? m_addr : 32'h0);
    chk32("mem_wdata", mem_wdata, (m_owner == 2 && m_write) ? m_wdata : 32'h0);
    chk1 ("iready",    iready,    m_iready);
    chk1 ("dready",    dready,    m_dready);
    chk1 ("err",       err,       m_err);
    chk32("instr",     instr,     m_instr);
    chk32("dload",     dload,     m_dload);
  end

  task automatic do_reset();
    nRST = 1'b0;
    tick();
    tick();
    nRST = 1'b1;
  endtask

  int ren_cycles;
  bit seen;

  initial begin
    nRST = 1'b1;
    iren = 0; dren = 0; dwen = 0; mem_ack = 0;
    iaddr = 0; daddr = 0; dstore = 0; mem_rdata = 0;
    #1 nRST = 1'b0;
    tick(); tick();
    nRST = 1'b1;

    // reset values
    chk1 ("rst_iready", iready, 1'b0);
    chk1 ("rst_mem_ren", mem_ren, 1'b0);
    chk1 ("rst_err", err, 1'b0);
    chk32("rst_instr", instr, 32'h0);
    chk32("rst_dload", dload, 32'h0);

    // zero-wait fetch
    iren = 1; iaddr = 32'h10; mem_ack = 1; mem_rdata = 32'h00500093;
    tick();
    chk1 ("fetch_ren", mem_ren, 1'b1);
    chk32("fetch_addr", mem_addr, 32'h10);
    tick();
    chk1 ("fetch_ren_drop", mem_ren, 1'b0);
    chk1 ("fetch_iready", iready, 1'b1);
    chk32("fetch_instr", instr, 32'h00500093);
    iren = 0;
    tick();
    chk1 ("fetch_iready_once", iready, 1'b0);

    // tie after reset: data first, then fetch in the dready cycle
    do_reset();
    iren = 1; dren = 1; iaddr = 32'h40; daddr = 32'h100; mem_ack = 1; mem_rdata = 32'h11;
    tick();
    chk32("tie_first_addr", mem_addr, 32'h100);
    chk1 ("tie_first_ren", mem_ren, 1'b1);
    tick();
    chk1 ("tie_dready", dready, 1'b1);
    chk32("tie_dload", dload, 32'h11);
    dren = 0; mem_rdata = 32'h22;
    tick();
    chk32("tie_second_addr", mem_addr, 32'h40);
    tick();
    chk1 ("tie_iready", iready, 1'b1);
    chk32("tie_instr", instr, 32'h22);
    iren = 0;
    tick();
    iren = 1; dren = 1; iaddr = 32'h44; daddr = 32'h104;
    tick();
    chk32("tie_again_addr", mem_addr, 32'h104);
    tick();
    dren = 0;
    tick(); tick();
    iren = 0;
    tick();

    // store with three wait states, inputs changed mid-access
    mem_ack = 0; dwen = 1; daddr = 32'h200; dstore = 32'hDEADBEEF;
    tick();
    for (int k = 1; k <= 4; k++) begin
      chk1 ("st_wen", mem_wen, 1'b1);
      chk1 ("st_ren", mem_ren, 1'b0);
      chk32("st_addr", mem_addr, 32'h200);
      chk32("st_wdata", mem_wdata, 32'hDEADBEEF);
      if (k == 1) begin daddr = 32'h999; dstore = 32'h12345678; end
      if (k == 4) mem_ack = 1;
      tick();
    end
    chk1 ("st_wen_drop", mem_wen, 1'b0);
    chk1 ("st_dready", dready, 1'b1);
    chk1 ("st_no_err", err, 1'b0);
    chk32("st_dload_kept", dload, 32'h22);
    dwen = 0; mem_ack = 0;
    tick();
    chk1 ("st_dready_once", dready, 1'b0);

    // watchdog abort on a fetch
    iren = 1; iaddr = 32'h80;
    tick();
    for (int k = 1; k <= 4; k++) begin
      chk1("to_ren", mem_ren, 1'b1);
      tick();
    end
    chk1 ("to_ren_drop", mem_ren, 1'b0);
    chk1 ("to_err", err, 1'b1);
    chk1 ("to_iready", iready, 1'b1);
    chk32("to_instr_kept", instr, 32'h22);
    iren = 0;
    tick();
    chk1 ("to_err_once", err, 1'b0);

    // reset in the middle of a store
    dwen = 1; daddr = 32'h300; dstore = 32'hA5A5A5A5;
    tick(); tick();
    chk1("rm_wen", mem_wen, 1'b1);
    nRST = 1'b0;
    #1;
    chk1("rm_wen_async", mem_wen, 1'b0);
    chk1("rm_no_dready", dready, 1'b0);
    dwen = 0;
    tick(); tick();
    nRST = 1'b1;
    iren = 1; iaddr = 32'h310; mem_ack = 1; mem_rdata = 32'hCAFE0001;
    seen = 0;
    for (int k = 0; k < 10 && !seen; k++) begin
      tick();
      if (iready) seen = 1;
    end
    chk1 ("rm_served", seen, 1'b1);
    chk32("rm_instr", instr, 32'hCAFE0001);
    iren = 0;
    tick();

    // masking: request held through iready gives exactly one access
    iren = 1; iaddr = 32'h400; mem_rdata = 32'h77;
    ren_cycles = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (mem_ren) ren_cycles++;
      if (k == 2) begin
        chk1("mask_no_regrant", mem_ren, 1'b0);
        iren = 0;
      end
    end
    chk32("mask_one_access", 32'(ren_cycles), 32'd1);
    iren = 1;
    tick(); tick(); tick();
    chk1("mask_gap", mem_ren, 1'b0);
    tick();
    chk1("mask_second_access", mem_ren, 1'b1);
    iren = 0;
    tick(); tick();

    // random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      iren      = 1'($urandom_range(0, 1));
      dren      = 1'($urandom_range(0, 1));
      dwen      = ($urandom_range(0, 3) == 0);
      iaddr     = $urandom;
      daddr     = $urandom;
      dstore    = $urandom;
      mem_rdata = $urandom;
      mem_ack   = ($urandom_range(0, 9) < 3);
      tick();
    end
    iren = 0; dren = 0; dwen = 0; mem_ack = 1;
    tick(); tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
